// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite control register file: ap_start/done handshake plus three scalar kernel arguments.
// Define CTRL_IRQ_EN to build GIE/IER/ISR and the level interrupt; otherwise interrupt is tied low.
module axi_lite_ctrl_regs #(
   parameter int ADDR_BITS = 6,
   parameter int DATA_BITS = 32,
   parameter int STRB_BITS = DATA_BITS/8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 s_axi_control_AWVALID,
   output logic                 s_axi_control_AWREADY,
   input  logic [ADDR_BITS-1:0] s_axi_control_AWADDR,
   input  logic                 s_axi_control_WVALID,
   output logic                 s_axi_control_WREADY,
   input  logic [DATA_BITS-1:0] s_axi_control_WDATA,
   input  logic [STRB_BITS-1:0] s_axi_control_WSTRB,
   output logic                 s_axi_control_BVALID,
   input  logic                 s_axi_control_BREADY,
   output logic [1:0]           s_axi_control_BRESP,
   input  logic                 s_axi_control_ARVALID,
   output logic                 s_axi_control_ARREADY,
   input  logic [ADDR_BITS-1:0] s_axi_control_ARADDR,
   output logic                 s_axi_control_RVALID,
   input  logic                 s_axi_control_RREADY,
   output logic [DATA_BITS-1:0] s_axi_control_RDATA,
   output logic [1:0]           s_axi_control_RRESP,
   output logic                 ap_start,
   input  logic                 ap_done,
   input  logic                 ap_idle,
   input  logic                 ap_ready,
   output logic [DATA_BITS-1:0] arg0,
   output logic [DATA_BITS-1:0] arg1,
   output logic [DATA_BITS-1:0] arg2,
   output logic                 interrupt
);
   typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_t;
   typedef enum logic {RIDLE, RDATA} rstate_t;

   wstate_t              r_wstate;
   rstate_t              r_rstate;
   logic [3:0]           r_waddr;
   logic [DATA_BITS-1:0] r_rdata;
   logic                 r_ap_start;
   logic                 r_auto_restart;
   logic                 r_done;
   logic [DATA_BITS-1:0] r_arg [3];

   logic                 w_aw_hs;
   logic                 w_w_hs;
   logic                 w_ar_hs;
   logic                 w_wr_ctrl;
   logic [3:0]           w_raddr;
   logic [DATA_BITS-1:0] w_rdata;
   logic                 w_unused_addr;

   assign w_aw_hs   = s_axi_control_AWVALID && (r_wstate == WIDLE);
   assign w_w_hs    = s_axi_control_WVALID && (r_wstate == WDATA);
   assign w_ar_hs   = s_axi_control_ARVALID && (r_rstate == RIDLE);
   assign w_raddr   = s_axi_control_ARADDR[5:2];
   assign w_wr_ctrl = w_w_hs && (r_waddr == 4'h0) && s_axi_control_WSTRB[0];
   assign w_unused_addr = &{1'b0, s_axi_control_AWADDR[1:0], s_axi_control_ARADDR[1:0]};

   assign s_axi_control_AWREADY = (r_wstate == WIDLE);
   assign s_axi_control_WREADY  = (r_wstate == WDATA);
   assign s_axi_control_BVALID  = (r_wstate == WRESP);
   assign s_axi_control_BRESP   = 2'b00;
   assign s_axi_control_ARREADY = (r_rstate == RIDLE);
   assign s_axi_control_RVALID  = (r_rstate == RDATA);
   assign s_axi_control_RDATA   = r_rdata;
   assign s_axi_control_RRESP   = 2'b00;
   assign ap_start = r_ap_start;
   assign arg0     = r_arg[0];
   assign arg1     = r_arg[1];
   assign arg2     = r_arg[2];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wstate <= WIDLE;
         r_waddr  <= '0;
      end else begin
         case (r_wstate)
            WIDLE: if (w_aw_hs) begin
               r_waddr  <= s_axi_control_AWADDR[5:2];
               r_wstate <= WDATA;
            end
            WDATA: if (w_w_hs) r_wstate <= WRESP;
            WRESP: if (s_axi_control_BREADY) r_wstate <= WIDLE;
            default: r_wstate <= WIDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rstate <= RIDLE;
         r_rdata  <= '0;
      end else begin
         case (r_rstate)
            RIDLE: if (w_ar_hs) begin
               r_rdata  <= w_rdata;
               r_rstate <= RDATA;
            end
            RDATA: if (s_axi_control_RREADY) r_rstate <= RIDLE;
         endcase
      end
   end

   // Priority: a software start beats ap_ready, and a fresh ap_done beats clear-on-read.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ap_start     <= 1'b0;
         r_auto_restart <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         if (w_wr_ctrl) r_auto_restart <= s_axi_control_WDATA[7];
         if (w_wr_ctrl && s_axi_control_WDATA[0]) r_ap_start <= 1'b1;
         else if (ap_ready && !r_auto_restart)    r_ap_start <= 1'b0;
         if (ap_done)                             r_done <= 1'b1;
         else if (w_ar_hs && (w_raddr == 4'h0))   r_done <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 3; i++) r_arg[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            if (w_w_hs && (r_waddr == 4'(4 + i))) begin
               for (int unsigned b = 0; b < STRB_BITS; b++) begin
                  if (s_axi_control_WSTRB[b]) r_arg[i][8*b +: 8] <= s_axi_control_WDATA[8*b +: 8];
               end
            end
         end
      end
   end

`ifdef CTRL_IRQ_EN
   logic       r_gie;
   logic [1:0] r_ier;
   logic [1:0] r_isr;
   logic       r_irq;
   logic       w_gie_nxt;
   logic [1:0] w_ier_nxt;
   logic [1:0] w_isr_nxt;

   always_comb begin
      w_gie_nxt = r_gie;
      w_ier_nxt = r_ier;
      w_isr_nxt = r_isr;
      if (w_w_hs && s_axi_control_WSTRB[0]) begin
         case (r_waddr)
            4'h1: w_gie_nxt = s_axi_control_WDATA[0];
            4'h2: w_ier_nxt = s_axi_control_WDATA[1:0];
            4'h3: w_isr_nxt = r_isr ^ s_axi_control_WDATA[1:0];
            default: ;
         endcase
      end
      w_isr_nxt = w_isr_nxt | {ap_ready & r_ier[1], ap_done & r_ier[0]};
   end

   // Interrupt is flopped from next-state so it rises one cycle after the event.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_gie <= 1'b0;
         r_ier <= '0;
         r_isr <= '0;
         r_irq <= 1'b0;
      end else begin
         r_gie <= w_gie_nxt;
         r_ier <= w_ier_nxt;
         r_isr <= w_isr_nxt;
         r_irq <= w_gie_nxt & (|w_isr_nxt);
      end
   end

   assign interrupt = r_irq;
`else
   assign interrupt = 1'b0;
`endif

   always_comb begin
      w_rdata = '0;
      case (w_raddr)
         4'h0: w_rdata[7:0] = {r_auto_restart, 3'b000, ap_ready, ap_idle, r_done | ap_done, r_ap_start};
`ifdef CTRL_IRQ_EN
         4'h1: w_rdata[0]   = r_gie;
         4'h2: w_rdata[1:0] = r_ier;
         4'h3: w_rdata[1:0] = r_isr;
`endif
         4'h4: w_rdata = r_arg[0];
         4'h5: w_rdata = r_arg[1];
         4'h6: w_rdata = r_arg[2];
         default: ;
      endcase
   end
endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// Self-checking bench for axi_lite_ctrl_regs; read data is checked through an expected-value queue.
module tb_axi_lite_ctrl_regs;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        awvalid = 1'b0, awready;
   logic [5:0]  awaddr = '0;
   logic        wvalid = 1'b0, wready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        bvalid, bready = 1'b0;
   logic [1:0]  bresp;
   logic        arvalid = 1'b0, arready;
   logic [5:0]  araddr = '0;
   logic        rvalid, rready = 1'b0;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        ap_start, ap_done = 1'b0, ap_idle = 1'b0, ap_ready = 1'b0;
   logic [31:0] arg0, arg1, arg2;
   logic        interrupt;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   logic [31:0] exp_q[$];

   always #5 clock = ~clock;

   axi_lite_ctrl_regs #(.ADDR_BITS(6), .DATA_BITS(32)) dut (
      .clock(clock), .reset(reset),
      .s_axi_control_AWVALID(awvalid), .s_axi_control_AWREADY(awready), .s_axi_control_AWADDR(awaddr),
      .s_axi_control_WVALID(wvalid), .s_axi_control_WREADY(wready),
      .s_axi_control_WDATA(wdata), .s_axi_control_WSTRB(wstrb),
      .s_axi_control_BVALID(bvalid), .s_axi_control_BREADY(bready), .s_axi_control_BRESP(bresp),
      .s_axi_control_ARVALID(arvalid), .s_axi_control_ARREADY(arready), .s_axi_control_ARADDR(araddr),
      .s_axi_control_RVALID(rvalid), .s_axi_control_RREADY(rready),
      .s_axi_control_RDATA(rdata), .s_axi_control_RRESP(rresp),
      .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .arg0(arg0), .arg1(arg1), .arg2(arg2), .interrupt(interrupt)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Full write; rdy_in_w pulses ap_ready during the W handshake cycle.
   task automatic axi_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic rdy_in_w);
      int unsigned n;
      @(negedge clock); awvalid = 1'b1; awaddr = a;
      n = 0;
      while (!awready && n < 16) begin @(negedge clock); n++; end
      chk("awready_wait", 32'(n), 32'd0);
      @(negedge clock); awvalid = 1'b0; wvalid = 1'b1; wdata = d; wstrb = s; ap_ready = rdy_in_w;
      n = 0;
      while (!wready && n < 16) begin @(negedge clock); n++; end
      chk("wready_wait", 32'(n), 32'd0);
      @(negedge clock); wvalid = 1'b0; ap_ready = 1'b0; bready = 1'b1;
      n = 0;
      while (!bvalid && n < 16) begin @(negedge clock); n++; end
      chk("bvalid_lat", 32'(n), 32'd0);
      chk("bresp", 32'(bresp), 32'd0);
      @(negedge clock); bready = 1'b0;
   endtask

   task automatic axi_rd(input logic [5:0] a, input logic [31:0] exp, input logic done_in_ar);
      int unsigned n;
      @(negedge clock); arvalid = 1'b1; araddr = a; ap_done = done_in_ar;
      exp_q.push_back(exp);
      @(negedge clock); arvalid = 1'b0; ap_done = 1'b0;
      n = 0;
      while (!rvalid && n < 16) begin @(negedge clock); n++; end
      chk("rvalid_lat", 32'(n), 32'd0);
      if (rvalid) chk("rdata", rdata, exp_q.pop_front());
      else void'(exp_q.pop_front());
      chk("rresp", 32'(rresp), 32'd0);
      rready = 1'b1;
      @(negedge clock); rready = 1'b0;
   endtask

   task automatic pulse_done();
      @(negedge clock); ap_done = 1'b1;
      @(negedge clock); ap_done = 1'b0;
   endtask

   task automatic pulse_ready();
      @(negedge clock); ap_ready = 1'b1;
      @(negedge clock); ap_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clock);
      chk("rst_awready", 32'(awready), 32'd1);
      chk("rst_arready", 32'(arready), 32'd1);
      chk("rst_wready", 32'(wready), 32'd0);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ap_start", 32'(ap_start), 32'd0);
      chk("rst_arg0", arg0, 32'd0);
      chk("rst_irq", 32'(interrupt), 32'd0);
      @(negedge clock); reset = 1'b0;

      axi_wr(6'h10, 32'hDEADBEEF, 4'hF, 1'b0);
      chk("arg0", arg0, 32'hDEADBEEF);
      axi_rd(6'h10, 32'hDEADBEEF, 1'b0);
      axi_wr(6'h14, 32'hFFFFFFFF, 4'hF, 1'b0);
      axi_wr(6'h14, 32'h12345678, 4'h3, 1'b0);
      chk("arg1_strb", arg1, 32'hFFFF5678);
      axi_rd(6'h14, 32'hFFFF5678, 1'b0);
      axi_wr(6'h18, 32'hA5A51234, 4'hC, 1'b0);
      chk("arg2_strb", arg2, 32'hA5A50000);
      axi_rd(6'h18, 32'hA5A50000, 1'b0);

      axi_wr(6'h00, 32'h1, 4'h1, 1'b0);
      chk("start_set", 32'(ap_start), 32'd1);
      axi_rd(6'h00, 32'h01, 1'b0);
      pulse_ready();
      chk("start_clr", 32'(ap_start), 32'd0);
      axi_wr(6'h00, 32'h81, 4'h1, 1'b0);
      pulse_ready();
      chk("start_auto", 32'(ap_start), 32'd1);
      axi_rd(6'h00, 32'h81, 1'b0);
      axi_wr(6'h00, 32'h00, 4'h1, 1'b0);
      chk("start_w0", 32'(ap_start), 32'd1);
      pulse_ready();
      chk("start_clr2", 32'(ap_start), 32'd0);
      axi_wr(6'h00, 32'h01, 4'h2, 1'b0);
      chk("start_nostrb", 32'(ap_start), 32'd0);

      axi_wr(6'h3C, 32'hCAFEF00D, 4'hF, 1'b0);
      axi_rd(6'h3C, 32'h0, 1'b0);
      axi_rd(6'h20, 32'h0, 1'b0);

      ap_idle = 1'b1;
      pulse_done();
      axi_rd(6'h00, 32'h06, 1'b0);
      axi_rd(6'h00, 32'h04, 1'b0);
      axi_rd(6'h00, 32'h06, 1'b1);
      axi_rd(6'h00, 32'h06, 1'b0);
      axi_rd(6'h00, 32'h04, 1'b0);

      axi_wr(6'h00, 32'h01, 4'h1, 1'b1);
      chk("start_vs_ready", 32'(ap_start), 32'd1);
      axi_rd(6'h00, 32'h05, 1'b0);
      pulse_ready();
      chk("start_clr3", 32'(ap_start), 32'd0);

`ifdef CTRL_IRQ_EN
      axi_wr(6'h04, 32'h1, 4'h1, 1'b0);
      axi_wr(6'h08, 32'h1, 4'h1, 1'b0);
      axi_rd(6'h04, 32'h1, 1'b0);
      axi_rd(6'h08, 32'h1, 1'b0);
      chk("irq_idle", 32'(interrupt), 32'd0);
      @(negedge clock); ap_done = 1'b1;
      @(negedge clock); ap_done = 1'b0;
      chk("irq_set", 32'(interrupt), 32'd1);
      axi_rd(6'h0C, 32'h1, 1'b0);
      axi_wr(6'h0C, 32'h1, 4'h1, 1'b0);
      chk("irq_clr", 32'(interrupt), 32'd0);
      axi_rd(6'h0C, 32'h0, 1'b0);
      axi_wr(6'h08, 32'h3, 4'h1, 1'b0);
      pulse_ready();
      axi_rd(6'h0C, 32'h2, 1'b0);
      axi_wr(6'h0C, 32'h2, 4'h1, 1'b1);
      axi_rd(6'h0C, 32'h2, 1'b0);
      chk("irq_hw_win", 32'(interrupt), 32'd1);
`else
      axi_wr(6'h04, 32'h1, 4'h1, 1'b0);
      axi_wr(6'h08, 32'h3, 4'h1, 1'b0);
      pulse_done();
      @(negedge clock);
      chk("irq_off", 32'(interrupt), 32'd0);
      axi_rd(6'h04, 32'h0, 1'b0);
      axi_rd(6'h08, 32'h0, 1'b0);
      axi_rd(6'h0C, 32'h0, 1'b0);
`endif

      axi_wr(6'h00, 32'h01, 4'h1, 1'b0);
      @(negedge clock); awvalid = 1'b1; awaddr = 6'h18; arvalid = 1'b1; araddr = 6'h10;
      @(negedge clock); awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF;
      @(negedge clock); wvalid = 1'b0;
      chk("pre_rst_bvalid", 32'(bvalid), 32'd1);
      chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
      chk("pre_rst_arg2", arg2, 32'h55AA55AA);
      reset = 1'b1;
      #1;
      chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
      chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
      chk("mid_rst_rdata", rdata, 32'd0);
      chk("mid_rst_start", 32'(ap_start), 32'd0);
      chk("mid_rst_arg0", arg0, 32'd0);
      chk("mid_rst_arg1", arg1, 32'd0);
      chk("mid_rst_arg2", arg2, 32'd0);
      chk("mid_rst_irq", 32'(interrupt), 32'd0);
      @(negedge clock); reset = 1'b0;
      @(negedge clock);
      chk("post_rst_awready", 32'(awready), 32'd1);
      chk("post_rst_arready", 32'(arready), 32'd1);
      chk("post_rst_wready", 32'(wready), 32'd0);
      axi_rd(6'h10, 32'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/axi_lite_ctrl_regs.md
# axi_lite_ctrl_regs

AXI4-Lite control slave: the accelerator's register file. It sits directly downstream of the host bridge and answers its `s_axi_control_*` transactions. It exposes start/done handshaking and three scalar kernel arguments to the compute core. An optional level interrupt can be compiled in.

## Interface
Parameters:
- `ADDR_BITS`, default 6: AXI address width; byte addresses.
- `DATA_BITS`, default 32: AXI data width and width of each argument register.
- `STRB_BITS`, default `DATA_BITS/8`: write-strobe width.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `s_axi_control_AWVALID` in 1, `s_axi_control_AWREADY` out 1, `s_axi_control_AWADDR` in `ADDR_BITS`: write-address channel.
- `s_axi_control_WVALID` in 1, `s_axi_control_WREADY` out 1, `s_axi_control_WDATA` in `DATA_BITS`, `s_axi_control_WSTRB` in `STRB_BITS`: write-data channel.
- `s_axi_control_BVALID` out 1, `s_axi_control_BREADY` in 1, `s_axi_control_BRESP` out 2: write response; BRESP is always 0.
- `s_axi_control_ARVALID` in 1, `s_axi_control_ARREADY` out 1, `s_axi_control_ARADDR` in `ADDR_BITS`: read-address channel.
- `s_axi_control_RVALID` out 1, `s_axi_control_RREADY` in 1, `s_axi_control_RDATA` out `DATA_BITS`, `s_axi_control_RRESP` out 2: read-data channel; RRESP is always 0.
- `ap_start` out 1: core start request.
- `ap_done` in 1: one-cycle done pulse from the core.
- `ap_idle` in 1: core idle level.
- `ap_ready` in 1: one-cycle pulse; the core has accepted the start.
- `arg0`, `arg1`, `arg2` out `DATA_BITS` each: kernel scalar arguments.
- `interrupt` out 1: level interrupt. Present only with `CTRL_IRQ_EN`; otherwise tied to 0.

## Operation
Register map (byte offsets; only `ADDR[5:2]` is decoded):
- 0x00 CTRL, bits:
  - [0] ap_start: R/W1S.
  - [1] ap_done: RO, sticky, clear-on-read.
  - [2] ap_idle: RO, live.
  - [3] ap_ready: RO, live.
  - [7] auto_restart: R/W.
- 0x04 GIE: [0] global interrupt enable.
- 0x08 IER: [0] done enable, [1] ready enable.
- 0x0C ISR: [0] done, [1] ready; toggle-on-write-1.
- 0x10 `arg0`, 0x14 `arg1`, 0x18 `arg2`: R/W, byte-strobed.
- All other offsets read 0; writes to them are ignored but still acknowledged.

Write FSM:
- States: WIDLE → WDATA → WRESP → WIDLE.
- `AWREADY` = (state == WIDLE). On the AW handshake, latch the address.
- `WREADY` = (state == WDATA). On the W handshake, perform the register write in that same cycle, then move to WRESP.
- `BVALID` = (state == WRESP). Hold it until `BREADY`.

Read FSM:
- States: RIDLE → RDATA → RIDLE.
- `ARREADY` = (state == RIDLE).
- On the AR handshake, register the read data. If the address is 0x00, clear the ap_done sticky bit on the same edge.
- `RVALID` = (state == RDATA). `RDATA` stays stable until `RREADY`.

The read and write FSMs run independently and may be active at the same time.

ap_start:
- Writing 1 to CTRL[0] sets it; writing 0 has no effect.
- It clears on `ap_ready` when auto_restart = 0.
- It stays set on `ap_ready` when auto_restart = 1.

CTRL write strobes: the CTRL write is applied only if `WSTRB[0]` = 1.

## Timing
- Reset values: all registers 0, both FSMs idle.
  - Outputs in reset: `AWREADY` = 1, `ARREADY` = 1, `WREADY` = 0, `BVALID` = 0, `RVALID` = 0, `RDATA` = 0, `ap_start` = 0, `arg0`–`arg2` = 0, `interrupt` = 0.
- Write latency: AW handshake at cycle n, W accepted at n+1 at the earliest, `BVALID` at n+2. The register output updates at n+2.
- Read latency: AR handshake at n, `RVALID` with data at n+1.
- `ap_done` pulse in the same cycle as a CTRL-read AR handshake: the new event wins. The sticky bit stays 1, and the registered read data shows 1.
- `ap_ready` in the same cycle as a write of 1 to CTRL[0]: the write wins, and `ap_start` stays 1.
- ISR: a hardware set in the same cycle as a software toggle results in 1.
- Reset asserted mid-transaction: both FSMs go idle and all registers clear immediately. Any in-flight response is dropped.

## Configuration
- `CTRL_IRQ_EN` defined:
  - GIE, IER and ISR are implemented.
  - ISR[0] is set on `ap_done` when IER[0] = 1; ISR[1] is set on `ap_ready` when IER[1] = 1.
  - `interrupt` = GIE[0] & |ISR, registered, so it asserts 1 cycle after the event.
- `CTRL_IRQ_EN` undefined:
  - Offsets 0x04–0x0C read 0, and writes to them are acknowledged and ignored.
  - `interrupt` is constant 0.

## Test plan
- Write 0xDEADBEEF to 0x10 with WSTRB = 0xF, then read 0x10: `BVALID` 2 cycles after AW, `RDATA` = 0xDEADBEEF, `arg0` = 0xDEADBEEF.
- Write 0x12345678 to 0x14 with WSTRB = 0x3 over prior 0xFFFFFFFF: `arg1` = 0xFFFF5678.
- Write 0x1 to 0x00: `ap_start` = 1. Pulse `ap_ready`: `ap_start` = 0 next cycle. Repeat with 0x81: `ap_start` stays 1 after `ap_ready`.
- Pulse `ap_done`, then read 0x00 twice: bit1 = 1 on the first read and 0 on the second. Pulse `ap_done` in the AR handshake cycle: both reads return bit1 = 1.
- With `CTRL_IRQ_EN`: write GIE = 1, IER = 1, pulse `ap_done`: `interrupt` = 1 next cycle. Write ISR = 1: `interrupt` = 0.
- Assert `reset` while `BVALID` = 1: `BVALID` = 0 immediately, `arg0`–`arg2` = 0, and `AWREADY` = 1 after release.
